// File: rtl/vending_core_if.sv
// Command, coin and status bundle between the keyboard front-end and vending_core.
// The front-end uses the master modport and the controller uses the slave modport.
interface vending_core_if #(
  parameter int SLOTW  = 2,
  parameter int STOCKW = 4,
  parameter int MONEYW = 8,
  parameter int PASSW  = 6
);
  logic [1:0]        mode;
  logic              start;
  logic [SLOTW-1:0]  slot;
  logic [STOCKW-1:0] qty;
  logic [MONEYW-1:0] amount;
  logic [PASSW-1:0]  pass;
  logic              coin_valid;
  logic [MONEYW-1:0] coin_val;
  logic              cancel;
  logic              busy;
  logic              done;
  logic              dispense;
  logic [SLOTW-1:0]  disp_slot;
  logic              change_valid;
  logic [MONEYW-1:0] change_amt;
  logic [MONEYW-1:0] credit;
  logic [MONEYW-1:0] bank;
  logic [STOCKW-1:0] stock_out;
  logic [MONEYW-1:0] price_out;
  logic [3:0]        err;

  modport master (
    output mode, start, slot, qty, amount, pass, coin_valid, coin_val, cancel,
    input  busy, done, dispense, disp_slot, change_valid, change_amt,
           credit, bank, stock_out, price_out, err
  );

  modport slave (
    input  mode, start, slot, qty, amount, pass, coin_valid, coin_val, cancel,
    output busy, done, dispense, disp_slot, change_valid, change_amt,
           credit, bank, stock_out, price_out, err
  );
endinterface

// File: rtl/vending_core.sv
// Vending controller: per-slot stock and price, coin credit, buy/restock/withdraw/report.
// A command runs IDLE -> EXEC (decide and update) -> FIN (pulse results) -> IDLE.
module vending_core #(
  parameter int               NSLOT  = 4,
  parameter int               SLOTW  = 2,
  parameter int               STOCKW = 4,
  parameter int               MONEYW = 8,
  parameter int               PASSW  = 6,
  parameter logic [PASSW-1:0] PASS   = 6'b001101
) (
  input logic           clock,
  input logic           resetn,
  vending_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, FIN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [STOCKW-1:0] stock [NSLOT];
  logic [MONEYW-1:0] price [NSLOT];
  logic [MONEYW-1:0] credit, bank;

  logic [1:0]        cmd_mode;
  logic [SLOTW-1:0]  cmd_slot;
  logic [STOCKW-1:0] cmd_qty;
  logic [MONEYW-1:0] cmd_amount;
  logic [PASSW-1:0]  cmd_pass;

  logic [3:0]        pend_err;
  logic              pend_disp, pend_chg, pend_rep;
  logic [MONEYW-1:0] pend_chg_amt, pend_price_out;
  logic [STOCKW-1:0] pend_stock_out;

  logic              done_r, disp_r, chg_valid_r;
  logic [SLOTW-1:0]  disp_slot_r;
  logic [MONEYW-1:0] chg_amt_r, price_out_r;
  logic [STOCKW-1:0] stock_out_r;
  logic [3:0]        err_r;

  logic              do_cancel, accept_start, coin_ok;
  logic [MONEYW:0]   coin_sum, bank_sum;
  logic [STOCKW:0]   stock_sum;
  logic [3:0]        err_idle;
  logic              slot_ok, pass_ok;
  logic [STOCKW-1:0] cur_stock;
  logic [MONEYW-1:0] cur_price;

  logic [3:0]        dec_err;
  logic              dec_disp, dec_chg, dec_stock_wr, dec_price_wr, dec_rep;
  logic [MONEYW-1:0] dec_chg_amt, dec_credit, dec_bank, dec_price_out;
  logic [STOCKW-1:0] dec_stock, dec_stock_out;

  // Cancel with credit outranks both coins and a new command in the same cycle.
  assign do_cancel    = (state == IDLE) && bus.cancel && (credit != '0);
  assign accept_start = (state == IDLE) && bus.start && !do_cancel;
  assign coin_ok      = (state == IDLE) && !bus.cancel && bus.coin_valid;
  assign coin_sum     = {1'b0, credit} + {1'b0, bus.coin_val};

  always_comb begin
    err_idle = accept_start ? 4'b0000 : err_r;
    if (coin_ok && coin_sum[MONEYW])
      err_idle[3] = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_start) state_nxt = EXEC;
      EXEC:    state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slot_ok   = 1'b0;
    cur_stock = '0;
    cur_price = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (cmd_slot == SLOTW'(i)) begin
        slot_ok   = 1'b1;
        cur_stock = stock[i];
        cur_price = price[i];
      end
    end
  end

  assign pass_ok   = (cmd_pass == PASS);
  assign bank_sum  = {1'b0, bank} + {1'b0, cur_price};
  assign stock_sum = {1'b0, cur_stock} + {1'b0, cmd_qty};

  // Command outcome, evaluated while in EXEC; error checks follow their priority order.
  always_comb begin
    dec_err       = 4'b0000;
    dec_disp      = 1'b0;
    dec_chg       = 1'b0;
    dec_chg_amt   = '0;
    dec_stock_wr  = 1'b0;
    dec_stock     = cur_stock;
    dec_price_wr  = 1'b0;
    dec_credit    = credit;
    dec_bank      = bank;
    dec_rep       = 1'b0;
    dec_stock_out = '0;
    dec_price_out = '0;
    case (cmd_mode)
      2'b00: begin
        if (!slot_ok || cur_stock == '0) dec_err[0] = 1'b1;
        else if (credit < cur_price)     dec_err[1] = 1'b1;
        else if (bank_sum[MONEYW])       dec_err[3] = 1'b1;
        else begin
          dec_disp     = 1'b1;
          dec_stock_wr = 1'b1;
          dec_stock    = cur_stock - STOCKW'(1);
          dec_bank     = bank_sum[MONEYW-1:0];
          dec_chg      = 1'b1;
          dec_chg_amt  = credit - cur_price;
          dec_credit   = '0;
        end
      end
      2'b01: begin
        if (!pass_ok)      dec_err[2] = 1'b1;
        else if (!slot_ok) dec_err[0] = 1'b1;
        else begin
          dec_stock_wr = 1'b1;
          dec_price_wr = (cmd_amount != '0);
          if (stock_sum[STOCKW]) begin
            dec_stock  = '1;
            dec_err[3] = 1'b1;
          end else begin
            dec_stock  = stock_sum[STOCKW-1:0];
          end
        end
      end
      2'b10: begin
        if (!pass_ok)               dec_err[2] = 1'b1;
        else if (cmd_amount > bank) dec_err[1] = 1'b1;
        else begin
          dec_bank    = bank - cmd_amount;
          dec_chg     = 1'b1;
          dec_chg_amt = cmd_amount;
        end
      end
      default: begin
        dec_rep = 1'b1;
        if (!slot_ok) dec_err[0] = 1'b1;
        else begin
          dec_stock_out = cur_stock;
          dec_price_out = cur_price;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NSLOT; i++) begin
        stock[i] <= '0;
        price[i] <= '0;
      end
      credit         <= '0;
      bank           <= '0;
      cmd_mode       <= 2'b00;
      cmd_slot       <= '0;
      cmd_qty        <= '0;
      cmd_amount     <= '0;
      cmd_pass       <= '0;
      pend_err       <= 4'b0000;
      pend_disp      <= 1'b0;
      pend_chg       <= 1'b0;
      pend_rep       <= 1'b0;
      pend_chg_amt   <= '0;
      pend_stock_out <= '0;
      pend_price_out <= '0;
      done_r         <= 1'b0;
      disp_r         <= 1'b0;
      chg_valid_r    <= 1'b0;
      disp_slot_r    <= '0;
      chg_amt_r      <= '0;
      stock_out_r    <= '0;
      price_out_r    <= '0;
      err_r          <= 4'b0000;
    end else begin
      done_r      <= 1'b0;
      disp_r      <= 1'b0;
      chg_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (do_cancel) begin
            chg_valid_r <= 1'b1;
            chg_amt_r   <= credit;
            credit      <= '0;
          end else begin
            err_r <= err_idle;
            if (coin_ok && !coin_sum[MONEYW])
              credit <= coin_sum[MONEYW-1:0];
            if (accept_start) begin
              cmd_mode   <= bus.mode;
              cmd_slot   <= bus.slot;
              cmd_qty    <= bus.qty;
              cmd_amount <= bus.amount;
              cmd_pass   <= bus.pass;
            end
          end
        end
        EXEC: begin
          for (int i = 0; i < NSLOT; i++) begin
            if (cmd_slot == SLOTW'(i)) begin
              if (dec_stock_wr) stock[i] <= dec_stock;
              if (dec_price_wr) price[i] <= cmd_amount;
            end
          end
          credit         <= dec_credit;
          bank           <= dec_bank;
          pend_err       <= dec_err;
          pend_disp      <= dec_disp;
          pend_chg       <= dec_chg;
          pend_chg_amt   <= dec_chg_amt;
          pend_rep       <= dec_rep;
          pend_stock_out <= dec_stock_out;
          pend_price_out <= dec_price_out;
        end
        FIN: begin
          done_r      <= 1'b1;
          disp_r      <= pend_disp;
          chg_valid_r <= pend_chg;
          err_r       <= pend_err;
          if (pend_disp) disp_slot_r <= cmd_slot;
          if (pend_chg)  chg_amt_r   <= pend_chg_amt;
          if (pend_rep) begin
            stock_out_r <= pend_stock_out;
            price_out_r <= pend_price_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_r;
  assign bus.dispense     = disp_r;
  assign bus.disp_slot    = disp_slot_r;
  assign bus.change_valid = chg_valid_r;
  assign bus.change_amt   = chg_amt_r;
  assign bus.credit       = credit;
  assign bus.bank         = bank;
  assign bus.stock_out    = stock_out_r;
  assign bus.price_out    = price_out_r;
  assign bus.err          = err_r;
endmodule

// File: tb/tb_vending_core.sv
// Self-checking bench for vending_core: directed scenarios, then random traffic
// checked against a slot/credit/bank model built from plain integer arithmetic.
module tb_vending_core;
  localparam int NSLOT  = 4;
  localparam int SLOTW  = 2;
  localparam int STOCKW = 4;
  localparam int MONEYW = 8;
  localparam int PASSW  = 6;
  localparam int PASSV  = 13;
  localparam int MONEY_MAX = 255;
  localparam int STOCK_MAX = 15;
  localparam int K_COIN = 0, K_CANCEL = 1, K_CMD = 2, K_CANCOIN = 3;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;

  int stock_m [NSLOT];
  int price_m [NSLOT];
  int credit_m, bank_m, err_m, chgamt_m, disp_m, so_m, po_m;

  vending_core_if #(.SLOTW(SLOTW), .STOCKW(STOCKW), .MONEYW(MONEYW), .PASSW(PASSW)) vif ();

  vending_core #(
    .NSLOT(NSLOT), .SLOTW(SLOTW), .STOCKW(STOCKW), .MONEYW(MONEYW),
    .PASSW(PASSW), .PASS(6'b001101)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (vif)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NSLOT; i++) begin
      stock_m[i] = 0;
      price_m[i] = 0;
    end
    credit_m = 0; bank_m = 0; err_m = 0; chgamt_m = 0; disp_m = 0; so_m = 0; po_m = 0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, 32'(vif.busy), 0);
    checkOutput({tag, "_pulses"}, 32'({vif.done, vif.dispense, vif.change_valid}), 0);
    checkOutput({tag, "_credit"}, 32'(vif.credit), 0);
    checkOutput({tag, "_bank"}, 32'(vif.bank), 0);
    checkOutput({tag, "_err"}, 32'(vif.err), 0);
    checkOutput({tag, "_reports"}, 32'({vif.stock_out, vif.price_out, vif.change_amt, vif.disp_slot}), 0);
  endtask

  // Called just after a falling edge; drives one operation and checks its effect.
  task automatic applyStimulus(input int kind, input int md, input int sl, input int q,
                               input int amt, input int pw, input int cv);
    int e_disp, e_chg;
    e_disp = 0;
    e_chg  = 0;
    if (kind == K_CMD) begin
      vif.mode   = 2'(md);
      vif.slot   = SLOTW'(sl);
      vif.qty    = STOCKW'(q);
      vif.amount = MONEYW'(amt);
      vif.pass   = PASSW'(pw);
      vif.start  = 1'b1;
      @(negedge clock);
      vif.start = 1'b0;
      checkOutput("busy_exec", 32'(vif.busy), 1);
      checkOutput("done_t1", 32'(vif.done), 0);
      @(negedge clock);
      checkOutput("pulses_t2", 32'({vif.done, vif.dispense, vif.change_valid}), 0);
      err_m = 0;
      case (md)
        0: begin
          if (sl >= NSLOT || stock_m[sl] == 0) err_m = 1;
          else if (credit_m < price_m[sl]) err_m = 2;
          else if (bank_m + price_m[sl] > MONEY_MAX) err_m = 8;
          else begin
            e_disp = 1; e_chg = 1; disp_m = sl;
            stock_m[sl] -= 1;
            bank_m   += price_m[sl];
            chgamt_m = credit_m - price_m[sl];
            credit_m = 0;
          end
        end
        1: begin
          if (pw != PASSV) err_m = 4;
          else if (sl >= NSLOT) err_m = 1;
          else begin
            stock_m[sl] += q;
            if (stock_m[sl] > STOCK_MAX) begin
              stock_m[sl] = STOCK_MAX;
              err_m = 8;
            end
            if (amt != 0) price_m[sl] = amt;
          end
        end
        2: begin
          if (pw != PASSV) err_m = 4;
          else if (amt > bank_m) err_m = 2;
          else begin
            bank_m  -= amt;
            e_chg    = 1;
            chgamt_m = amt;
          end
        end
        default: begin
          if (sl >= NSLOT) begin err_m = 1; so_m = 0; po_m = 0; end
          else begin so_m = stock_m[sl]; po_m = price_m[sl]; end
        end
      endcase
      @(negedge clock);
      checkOutput("done", 32'(vif.done), 1);
      checkOutput("busy_after", 32'(vif.busy), 0);
      checkOutput("dispense", 32'(vif.dispense), 32'(e_disp));
      checkOutput("disp_slot", 32'(vif.disp_slot), 32'(disp_m));
      checkOutput("change_valid", 32'(vif.change_valid), 32'(e_chg));
      checkOutput("change_amt", 32'(vif.change_amt), 32'(chgamt_m));
      checkOutput("err", 32'(vif.err), 32'(err_m));
      checkOutput("credit", 32'(vif.credit), 32'(credit_m));
      checkOutput("bank", 32'(vif.bank), 32'(bank_m));
      checkOutput("stock_out", 32'(vif.stock_out), 32'(so_m));
      checkOutput("price_out", 32'(vif.price_out), 32'(po_m));
    end else begin
      vif.coin_valid = (kind == K_COIN || kind == K_CANCOIN);
      vif.coin_val   = MONEYW'(cv);
      vif.cancel     = (kind != K_COIN);
      @(negedge clock);
      vif.coin_valid = 1'b0;
      vif.cancel     = 1'b0;
      if (kind == K_COIN) begin
        if (credit_m + cv > MONEY_MAX) err_m = err_m | 8;
        else credit_m += cv;
      end else if (credit_m > 0) begin
        e_chg    = 1;
        chgamt_m = credit_m;
        credit_m = 0;
      end
      checkOutput("idle_change_valid", 32'(vif.change_valid), 32'(e_chg));
      checkOutput("idle_change_amt", 32'(vif.change_amt), 32'(chgamt_m));
      checkOutput("idle_credit", 32'(vif.credit), 32'(credit_m));
      checkOutput("idle_err", 32'(vif.err), 32'(err_m));
    end
  endtask

  initial begin
    int r, md, sl, amt, pw;
    vif.mode = 2'b00; vif.start = 1'b0; vif.slot = '0; vif.qty = '0; vif.amount = '0;
    vif.pass = '0; vif.coin_valid = 1'b0; vif.coin_val = '0; vif.cancel = 1'b0;
    resetModel();
    repeat (2) @(negedge clock);
    checkReset("reset");
    resetn = 1'b1;

    applyStimulus(K_CMD, 1, 1, 3, 25, PASSV, 0);
    applyStimulus(K_CMD, 3, 1, 0, 0, 0, 0);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 10);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 10);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 10);
    applyStimulus(K_CMD, 0, 1, 0, 0, 0, 0);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 10);
    applyStimulus(K_CMD, 0, 1, 0, 0, 0, 0);
    applyStimulus(K_CANCEL, 0, 0, 0, 0, 0, 0);
    applyStimulus(K_CMD, 1, 1, 4, 0, 0, 0);
    applyStimulus(K_CMD, 1, 1, 15, 0, PASSV, 0);
    applyStimulus(K_CMD, 3, 1, 0, 0, 0, 0);
    applyStimulus(K_CMD, 0, 0, 0, 0, 0, 0);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 100);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 100);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 50);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 10);
    applyStimulus(K_CANCOIN, 0, 0, 0, 0, 0, 20);
    applyStimulus(K_CMD, 2, 0, 0, 30, PASSV, 0);
    applyStimulus(K_CMD, 2, 0, 0, 25, PASSV, 0);
    applyStimulus(K_CMD, 2, 0, 0, 0, PASSV, 0);
    applyStimulus(K_CMD, 1, 2, 5, 0, PASSV, 0);
    applyStimulus(K_CMD, 0, 2, 0, 0, 0, 0);

    for (int i = 0; i < 120; i++) begin
      r  = $urandom_range(0, 9);
      md = $urandom_range(0, 3);
      sl = $urandom_range(0, NSLOT - 1);
      pw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : PASSV;
      amt = (md == 2) ? $urandom_range(0, bank_m + 10) : $urandom_range(0, 40);
      if (r < 4)       applyStimulus(K_COIN, 0, 0, 0, 0, 0, $urandom_range(0, 80));
      else if (r == 4) applyStimulus(K_CANCEL, 0, 0, 0, 0, 0, 0);
      else if (r == 5) applyStimulus(K_CANCOIN, 0, 0, 0, 0, 0, $urandom_range(1, 30));
      else             applyStimulus(K_CMD, md, sl, $urandom_range(0, 8), amt, pw, 0);
    end

    // Reset while the command sits in EXEC must abort it without any pulse.
    applyStimulus(K_CMD, 1, 3, 2, 5, PASSV, 0);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 20);
    vif.mode = 2'b00; vif.slot = SLOTW'(3); vif.start = 1'b1;
    @(negedge clock);
    vif.start = 1'b0;
    checkOutput("busy_pre_reset", 32'(vif.busy), 1);
    #2 resetn = 1'b0;
    #1 checkReset("mid_exec");
    repeat (2) begin
      @(negedge clock);
      checkOutput("no_pulse_after_reset", 32'({vif.done, vif.dispense, vif.change_valid}), 0);
    end
    resetn = 1'b1;
    resetModel();
    applyStimulus(K_CMD, 3, 3, 0, 0, 0, 0);
    applyStimulus(K_COIN, 0, 0, 0, 0, 0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
